// File: rtl/pulse_stretch_generator.sv
// Edge-to-level generator: turns single-cycle requests into HOLD_CYCLES-wide level pulses
// separated by at least GAP_CYCLES low cycles, queueing (by count) requests that arrive mid-pulse.
module pulse_stretch_generator #(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int MAX_PENDING = 7,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_abort,
   input  logic              i_clr_ovf,
   output logic              o_level,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);

   localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W  = $clog2(MAX_HG) + 1;
   localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             r_state, w_state_nx;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
   logic [PEND_W-1:0]  r_pend, w_pend_nx;
   logic               r_ovf, w_ovf_nx;
   logic               r_level, r_busy;
   logic               w_cnt_zero, w_full;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_full     = (r_pend == PEND_MAX);

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_pend_nx  = r_pend;
      w_ovf_nx   = r_ovf;
      // Clear first so a drop in the same cycle overrides it.
      if (i_clr_ovf) w_ovf_nx = 1'b0;
      if (i_abort) begin
         w_state_nx = IDLE;
         w_cnt_nx   = '0;
         w_pend_nx  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req) begin
                  w_state_nx = HIGH;
                  w_cnt_nx   = HOLD_LD;
               end
            end
            HIGH: begin
               if (w_cnt_zero) begin
                  w_state_nx = GAP;
                  w_cnt_nx   = GAP_LD;
               end else begin
                  w_cnt_nx = r_cnt - 1'b1;
               end
               if (i_req) begin
                  if (w_full) w_ovf_nx  = 1'b1;
                  else        w_pend_nx = r_pend + 1'b1;
               end
            end
            GAP: begin
               if (w_cnt_zero) begin
                  // A request at gap end never drops: it cancels a pop or starts the pulse itself.
                  if (r_pend != '0) begin
                     w_state_nx = HIGH;
                     w_cnt_nx   = HOLD_LD;
                     if (!i_req) w_pend_nx = r_pend - 1'b1;
                  end else if (i_req) begin
                     w_state_nx = HIGH;
                     w_cnt_nx   = HOLD_LD;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end else begin
                  w_cnt_nx = r_cnt - 1'b1;
                  if (i_req) begin
                     if (w_full) w_ovf_nx  = 1'b1;
                     else        w_pend_nx = r_pend + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
               w_pend_nx  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_pend  <= w_pend_nx;
         r_ovf   <= w_ovf_nx;
         r_level <= (w_state_nx == HIGH);
         r_busy  <= (w_state_nx != IDLE);
      end
   end

   assign o_level    = r_level;
   assign o_busy     = r_busy;
   assign o_pending  = r_pend;
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretch_generator.sv
// Directed bench for pulse_stretch_generator (HOLD=16, GAP=8, MAX_PENDING=7).
// Cycle c means the interval after rising edge c; inputs and samples happen on falling edges.
module tb_pulse_stretch_generator;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_req, i_abort, i_clr_ovf;
   logic       o_level, o_busy, o_overflow;
   logic [2:0] o_pending;

   int vecs = 0;
   int errs = 0;

   pulse_stretch_generator #(
      .HOLD_CYCLES(16), .GAP_CYCLES(8), .MAX_PENDING(7), .PEND_W(3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_abort    (i_abort),
      .i_clr_ovf  (i_clr_ovf),
      .o_level    (o_level),
      .o_busy     (o_busy),
      .o_pending  (o_pending),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      vecs++;
      if ({o_level, o_busy, o_pending, o_overflow} !== 6'b0) begin
         errs++;
         $display("FAIL reset outputs got %b required 000000", {o_level, o_busy, o_pending, o_overflow});
      end
   endtask

   task automatic test_single();
      logic el, eb;
      for (int c = 0; c <= 26; c++) begin
         if (c > 0) begin
            el = (c <= 16);
            eb = (c <= 24);
            vecs++;
            if (o_level !== el) begin errs++; $display("FAIL single level c=%0d got %b required %b", c, o_level, el); end
            vecs++;
            if (o_busy !== eb) begin errs++; $display("FAIL single busy c=%0d got %b required %b", c, o_busy, eb); end
         end
         i_req = (c == 0);
         @(negedge clk);
      end
      i_req = 1'b0;
   endtask

   task automatic test_three_reqs();
      logic el, eb;
      logic [2:0] ep;
      for (int c = 0; c <= 75; c++) begin
         if (c > 0) begin
            el = (c >= 1 && c <= 16) || (c >= 25 && c <= 40) || (c >= 49 && c <= 64);
            eb = (c <= 72);
            ep = (c < 4) ? 3'd0 : (c < 6) ? 3'd1 : (c < 25) ? 3'd2 : (c < 49) ? 3'd1 : 3'd0;
            vecs++;
            if (o_level !== el) begin errs++; $display("FAIL three level c=%0d got %b required %b", c, o_level, el); end
            vecs++;
            if (o_busy !== eb) begin errs++; $display("FAIL three busy c=%0d got %b required %b", c, o_busy, eb); end
            vecs++;
            if (o_pending !== ep) begin errs++; $display("FAIL three pending c=%0d got %0d required %0d", c, o_pending, ep); end
         end
         i_req = (c == 0) || (c == 3) || (c == 5);
         @(negedge clk);
      end
      i_req = 1'b0;
   endtask

   task automatic test_saturate();
      for (int c = 0; c <= 33; c++) begin
         if (c == 8) begin
            vecs++;
            if (o_pending !== 3'd7 || o_overflow !== 1'b0) begin
               errs++; $display("FAIL sat full c=8 got pend=%0d ovf=%b required pend=7 ovf=0", o_pending, o_overflow);
            end
         end
         if (c == 9 || c == 30) begin
            vecs++;
            if (o_pending !== 3'd7 || o_overflow !== 1'b1) begin
               errs++; $display("FAIL sat ovf c=%0d got pend=%0d ovf=%b required pend=7 ovf=1", c, o_pending, o_overflow);
            end
         end
         if (c == 30) begin
            vecs++;
            if (o_level !== 1'b1) begin errs++; $display("FAIL sat level c=30 got %b required 1", o_level); end
         end
         if (c == 31) begin
            vecs++;
            if (o_pending !== 3'd0 || o_busy !== 1'b0 || o_overflow !== 1'b1) begin
               errs++; $display("FAIL sat abort c=31 got pend=%0d busy=%b ovf=%b required 0,0,1", o_pending, o_busy, o_overflow);
            end
         end
         if (c == 32) begin
            vecs++;
            if (o_overflow !== 1'b0) begin errs++; $display("FAIL sat clr c=32 got %b required 0", o_overflow); end
         end
         i_req     = (c < 30);
         i_abort   = (c == 30);
         i_clr_ovf = (c == 31);
         @(negedge clk);
      end
      i_req = 1'b0; i_abort = 1'b0; i_clr_ovf = 1'b0;
   endtask

   task automatic test_gap_end_req_empty();
      for (int c = 0; c <= 50; c++) begin
         if (c == 24) begin
            vecs++;
            if (o_level !== 1'b0 || o_busy !== 1'b1) begin errs++; $display("FAIL gapend0 c=24 got lvl=%b busy=%b required 0,1", o_level, o_busy); end
         end
         if (c == 25 || c == 40) begin
            vecs++;
            if (o_level !== 1'b1 || o_pending !== 3'd0) begin errs++; $display("FAIL gapend0 c=%0d got lvl=%b pend=%0d required 1,0", c, o_level, o_pending); end
         end
         if (c == 41) begin
            vecs++;
            if (o_level !== 1'b0 || o_busy !== 1'b1) begin errs++; $display("FAIL gapend0 c=41 got lvl=%b busy=%b required 0,1", o_level, o_busy); end
         end
         if (c == 49) begin
            vecs++;
            if (o_busy !== 1'b0) begin errs++; $display("FAIL gapend0 idle c=49 got %b required 0", o_busy); end
         end
         i_req = (c == 0) || (c == 24);
         @(negedge clk);
      end
      i_req = 1'b0;
   endtask

   task automatic test_gap_end_req_pending();
      for (int c = 0; c <= 52; c++) begin
         if (c == 4 || c == 48) begin
            vecs++;
            if (o_pending !== 3'd2) begin errs++; $display("FAIL gapend2 pend c=%0d got %0d required 2", c, o_pending); end
         end
         if (c == 25) begin
            vecs++;
            if (o_level !== 1'b1 || o_pending !== 3'd2) begin errs++; $display("FAIL gapend2 c=25 got lvl=%b pend=%0d required 1,2", o_level, o_pending); end
         end
         if (c == 49) begin
            vecs++;
            if (o_level !== 1'b1 || o_pending !== 3'd1) begin errs++; $display("FAIL gapend2 pop c=49 got lvl=%b pend=%0d required 1,1", o_level, o_pending); end
         end
         if (c == 51) begin
            vecs++;
            if (o_busy !== 1'b0 || o_pending !== 3'd0) begin errs++; $display("FAIL gapend2 abort c=51 got busy=%b pend=%0d required 0,0", o_busy, o_pending); end
         end
         i_req   = (c == 0) || (c == 2) || (c == 3) || (c == 24);
         i_abort = (c == 50);
         @(negedge clk);
      end
      i_req = 1'b0; i_abort = 1'b0;
   endtask

   task automatic test_abort();
      for (int c = 0; c <= 40; c++) begin
         if (c == 4 || c == 5) begin
            vecs++;
            if (o_pending !== 3'd3 || o_level !== 1'b1) begin errs++; $display("FAIL abort pre c=%0d got pend=%0d lvl=%b required 3,1", c, o_pending, o_level); end
         end
         if (c >= 6) begin
            vecs++;
            if (o_level !== 1'b0 || o_busy !== 1'b0 || o_pending !== 3'd0) begin
               errs++; $display("FAIL abort post c=%0d got lvl=%b busy=%b pend=%0d required 0,0,0", c, o_level, o_busy, o_pending);
            end
         end
         i_req   = (c <= 3) || (c == 5);
         i_abort = (c == 5);
         @(negedge clk);
      end
      i_req = 1'b0; i_abort = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int c = 0; c <= 5; c++) begin
         if (c == 5) begin
            vecs++;
            if (o_level !== 1'b1 || o_pending !== 3'd1) begin errs++; $display("FAIL areset pre got lvl=%b pend=%0d required 1,1", o_level, o_pending); end
         end
         i_req = (c == 0) || (c == 2);
         if (c < 5) @(negedge clk);
      end
      i_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      vecs++;
      if ({o_level, o_busy, o_pending, o_overflow} !== 6'b0) begin
         errs++; $display("FAIL areset immediate got %b required 000000", {o_level, o_busy, o_pending, o_overflow});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         vecs++;
         if ({o_level, o_busy, o_pending} !== 5'b0) begin
            errs++; $display("FAIL areset hold k=%0d got %b required 00000", c, {o_level, o_busy, o_pending});
         end
      end
      i_req = 1'b1;
      @(negedge clk);
      i_req = 1'b0;
      vecs++;
      if (o_level !== 1'b1 || o_busy !== 1'b1) begin errs++; $display("FAIL areset newreq got lvl=%b busy=%b required 1,1", o_level, o_busy); end
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_abort = 1'b0; i_clr_ovf = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_three_reqs();
      test_saturate();
      test_gap_end_req_empty();
      test_gap_end_req_pending();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
